// File: rtl/mult_acc_sub.sv
// Sequential signed multiply-accumulate: result = inA*inB -/+ inC over N+1 cycles.
// Build option: define MULT_ACC_SUB_SAT_EN to saturate overflowing results instead of wrapping.
module mult_acc_sub #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic [N-1:0] inC,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         ready,
  output logic         done
);

  localparam int W  = 2 * N + 1;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    ADDSUB = 2'd2
  } state_t;

  state_t         state_r;
  logic [2*N-1:0] acc_r;
  logic [2*N-1:0] mcand_r;
  logic [N-1:0]   mplier_r;
  logic [N-1:0]   c_r;
  logic           mode_r;
  logic           neg_r;
  logic [CW-1:0]  cnt_r;

  logic [N-1:0]   a_mag_s;
  logic [N-1:0]   b_mag_s;
  logic [W-1:0]   prod_s;
  logic [W-1:0]   c_ext_s;
  logic [W-1:0]   exact_s;
  logic           ovf_s;
  logic [N-1:0]   res_s;

  // Value fits N signed bits only if bits [W-1:N-1] are all copies of the sign.
  function automatic logic ovf_f(input logic [W-1:0] v);
    logic [W-N:0] top;
    top = v[W-1:N-1];
    return !((&top) || !(|top));
  endfunction

  // Choose the N-bit output for an exact value, clamping or wrapping on overflow.
  function automatic logic [N-1:0] fit_f(input logic [W-1:0] v, input logic ovf);
    logic [N-1:0] r;
    r = v[N-1:0];
`ifdef MULT_ACC_SUB_SAT_EN
    if (ovf) begin
      r = v[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      r = v[N-1:0];
    end
`else
    if (ovf) begin
      r = v[N-1:0];
    end else begin
      r = v[N-1:0];
    end
`endif
    return r;
  endfunction

  // Magnitudes are N-bit unsigned so that -2^(N-1) maps to 2^(N-1) without loss.
  always_comb begin
    a_mag_s = inA[N-1] ? (~inA + N'(1)) : inA;
    b_mag_s = inB[N-1] ? (~inB + N'(1)) : inB;
  end

  // Signed exact product and accumulate at 2N+1 bits.
  always_comb begin
    prod_s  = neg_r ? (W'(0) - {1'b0, acc_r}) : {1'b0, acc_r};
    c_ext_s = {{(N+1){c_r[N-1]}}, c_r};
    if (mode_r) begin
      exact_s = prod_s + c_ext_s;
    end else begin
      exact_s = prod_s - c_ext_s;
    end
    ovf_s = ovf_f(exact_s);
    res_s = fit_f(exact_s, ovf_s);
  end

  // Control FSM, shift-add datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      c_r      <= '0;
      mode_r   <= 1'b0;
      neg_r    <= 1'b0;
      cnt_r    <= '0;
      result   <= '0;
      overflow <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r    <= '0;
            mcand_r  <= {{N{1'b0}}, a_mag_s};
            mplier_r <= b_mag_s;
            c_r      <= inC;
            mode_r   <= mode;
            neg_r    <= inA[N-1] ^ inB[N-1];
            cnt_r    <= '0;
            ready    <= 1'b0;
            state_r  <= MULT;
          end else begin
            ready    <= 1'b1;
          end
        end
        MULT: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == CW'(N - 1)) begin
            state_r <= ADDSUB;
          end else begin
            state_r <= MULT;
          end
        end
        ADDSUB: begin
          result   <= res_s;
          overflow <= ovf_s;
          done     <= 1'b1;
          ready    <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_acc_sub.sv
// Directed, table-driven bench for mult_acc_sub at N=32 and N=8.
// Expected results follow the MULT_ACC_SUB_SAT_EN build option.
module tb_mult_acc_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        s32_start, s32_mode;
  logic [31:0] a32, b32, c32, r32;
  logic        o32, rdy32, d32;
  logic        s8_start, s8_mode;
  logic [7:0]  a8, b8, c8, r8;
  logic        o8, rdy8, d8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_acc_sub #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(s32_start), .mode(s32_mode),
    .inA(a32), .inB(b32), .inC(c32),
    .result(r32), .overflow(o32), .ready(rdy32), .done(d32)
  );

  mult_acc_sub #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode),
    .inA(a8), .inB(b8), .inC(c8),
    .result(r8), .overflow(o8), .ready(rdy8), .done(d8)
  );

  typedef struct {
    bit          w8;
    logic [31:0] a, b, c;
    bit          mode;
    logic [31:0] r_wrap, r_sat;
    bit          ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op on the chosen DUT, wait for done and check latency/results.
  task automatic run_op(input vec_t v, input string nm);
    int lat;
    logic [31:0] er;
    er = v.r_wrap;
`ifdef MULT_ACC_SUB_SAT_EN
    er = v.r_sat;
`endif
    if (v.w8) begin
      a8 = v.a[7:0]; b8 = v.b[7:0]; c8 = v.c[7:0]; s8_mode = v.mode; s8_start = 1'b1;
    end else begin
      a32 = v.a; b32 = v.b; c32 = v.c; s32_mode = v.mode; s32_start = 1'b1;
    end
    tick();
    s8_start = 1'b0; s32_start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      lat = k;
      if ((v.w8 && d8) || (!v.w8 && d32)) break;
    end
    if (v.w8) begin
      chk({nm, " latency"}, 64'(lat), 64'd9);
      chk({nm, " result"}, {56'd0, r8}, {56'd0, er[7:0]});
      chk({nm, " overflow"}, {63'd0, o8}, {63'd0, v.ovf});
      chk({nm, " ready"}, {63'd0, rdy8}, 64'd1);
      tick();
      chk({nm, " done width"}, {63'd0, d8}, 64'd0);
    end else begin
      chk({nm, " latency"}, 64'(lat), 64'd33);
      chk({nm, " result"}, {32'd0, r32}, {32'd0, er});
      chk({nm, " overflow"}, {63'd0, o32}, {63'd0, v.ovf});
      chk({nm, " ready"}, {63'd0, rdy32}, 64'd1);
      tick();
      chk({nm, " done width"}, {63'd0, d32}, 64'd0);
    end
  endtask

  initial begin
    int lat, seen;
    int pulses[3];
    int np;

    vecs[0]  = '{1'b0, 32'd13, 32'd12, 32'd100, 1'b0, -32'sd0 + 32'd56, 32'd56, 1'b0};
    vecs[1]  = '{1'b0, 32'd4, 32'd8, 32'd59, 1'b0, -32'sd27, -32'sd27, 1'b0};
    vecs[2]  = '{1'b0, 32'd10, -32'sd2, 32'd38, 1'b1, 32'd18, 32'd18, 1'b0};
    vecs[3]  = '{1'b0, -32'sd10, -32'sd2, 32'd38, 1'b0, -32'sd18, -32'sd18, 1'b0};
    vecs[4]  = '{1'b0, -32'sd1, -32'sd2, 32'd38, 1'b0, -32'sd36, -32'sd36, 1'b0};
    vecs[5]  = '{1'b0, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'd1, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 32'd0, 32'h7FFF_FFFF, 1'b1};
    vecs[9]  = '{1'b1, 32'd127, 32'd127, 32'd0, 1'b0, 32'd1, 32'd127, 1'b1};
    vecs[10] = '{1'b1, -32'sd128, -32'sd128, 32'd0, 1'b0, 32'd0, 32'd127, 1'b1};
    vecs[11] = '{1'b1, -32'sd8, 32'd16, 32'd0, 1'b0, 32'h80, 32'h80, 1'b0};

    rst = 1'b1; s32_start = 1'b0; s8_start = 1'b0; s32_mode = 1'b0; s8_mode = 1'b0;
    a32 = '0; b32 = '0; c32 = '0; a8 = '0; b8 = '0; c8 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset result", {32'd0, r32}, 64'd0);
    chk("reset overflow", {63'd0, o32}, 64'd0);
    chk("reset ready", {63'd0, rdy32}, 64'd1);
    chk("reset done", {63'd0, d32}, 64'd0);
    chk("reset ready8", {63'd0, rdy8}, 64'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start during an operation is ignored; operands stay latched.
    a32 = 32'd13; b32 = 32'd12; c32 = 32'd100; s32_mode = 1'b0; s32_start = 1'b1;
    tick();
    s32_start = 1'b0;
    lat = 0;
    seen = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == 4) begin
        a32 = 32'd7; b32 = 32'd7; c32 = 32'd1; s32_mode = 1'b1; s32_start = 1'b1;
      end else begin
        s32_start = 1'b0;
      end
      tick();
      lat = k;
      if (d32) break;
    end
    s32_start = 1'b0;
    chk("ignore latency", 64'(lat), 64'd33);
    chk("ignore result", {32'd0, r32}, 64'd56);
    tick();
    chk("ignore no relaunch", {63'd0, rdy32}, 64'd1);

    // Launch does not disturb result; reset mid-operation aborts it.
    a32 = 32'd4; b32 = 32'd8; c32 = 32'd59; s32_start = 1'b1;
    tick();
    s32_start = 1'b0;
    chk("launch holds result", {32'd0, r32}, 64'd56);
    chk("launch ready low", {63'd0, rdy32}, 64'd0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort ready", {63'd0, rdy32}, 64'd1);
    chk("abort result", {32'd0, r32}, 64'd0);
    chk("abort done", {63'd0, d32}, 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (d32) seen++;
    end
    chk("abort no done", 64'(seen), 64'd0);

    // Start held high: back-to-back operations with one idle cycle between.
    a32 = 32'd4; b32 = 32'd8; c32 = 32'd59; s32_mode = 1'b0; s32_start = 1'b1;
    np = 0;
    for (int k = 1; k <= 300 && np < 3; k++) begin
      tick();
      if (d32) begin
        pulses[np] = k;
        np++;
        chk($sformatf("b2b%0d result", np), {32'd0, r32}, {32'd0, -32'sd27});
        chk($sformatf("b2b%0d ready", np), {63'd0, rdy32}, 64'd1);
        if (np < 3) begin
          tick();
          k++;
          chk($sformatf("b2b%0d relaunch", np), {63'd0, rdy32}, 64'd0);
        end
      end
    end
    s32_start = 1'b0;
    chk("b2b pulses", 64'(np), 64'd3);
    if (np == 3) begin
      chk("b2b gap1", 64'(pulses[1] - pulses[0]), 64'd34);
      chk("b2b gap2", 64'(pulses[2] - pulses[1]), 64'd34);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_acc_sub.md
MULT_ACC_SUB -- requirements
Module: mult_acc_sub

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits; legal range 4..64.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to launch an operation.
REQ-005 SHALL have port mode, input, 1, operation select: 0 = inA*inB - inC, 1 = inA*inB + inC.
REQ-006 SHALL have ports inA, inB, inC, input, N each, two's-complement signed operands.
REQ-007 SHALL have port result, output, N, signed result.
REQ-008 SHALL have port overflow, output, 1, exact result not representable in N signed bits.
REQ-009 SHALL have port ready, output, 1, idle and able to accept start.
REQ-010 SHALL have port done, output, 1, one-cycle pulse on completion.

Function
REQ-011 SHALL implement states IDLE, MULT, ADDSUB; ready = 1 only in IDLE.
REQ-012 SHALL launch when start=1 and ready=1 at a rising edge: latch inA, inB, inC, mode; clear step counter; go to MULT.
REQ-013 SHALL ignore start while ready=0; latched operands unaffected by input changes during an operation.
REQ-014 SHALL compute the product sequentially, one multiplier bit per cycle, N cycles in MULT, giving the exact 2N-bit signed product for all operand combinations, including -2^(N-1) * -2^(N-1).
REQ-015 SHALL move MULT -> ADDSUB after the Nth step, then ADDSUB -> IDLE after one cycle.
REQ-016 SHALL form the exact sum/difference at 2N+1 bits in ADDSUB; with inC sign-extended.
REQ-017 SHALL update result, overflow and assert done on the ADDSUB -> IDLE edge; ready rises at the same edge, exactly N+1 edges after the launching edge.
REQ-018 SHALL set overflow = 1 when the exact 2N+1-bit value lies outside [-2^(N-1), 2^(N-1)-1], else 0.
REQ-019 SHALL, when overflow = 1 and saturation is disabled, output the low N bits of the exact value.
REQ-020 SHALL hold result and overflow stable from completion until the next completion; they SHALL NOT change at launch.
REQ-021 SHALL drive done high for exactly one cycle per completed operation.
REQ-022 SHALL relaunch on the completion edge+1 if start is still high when ready returns to 1. Holding start high gives back-to-back operations.

Reset
REQ-023 SHALL, on any rising edge with rst=1, enter IDLE with result=0, overflow=0, done=0, ready=1, and counter cleared, regardless of state.
REQ-024 SHALL give rst priority over start in the same cycle; an operation interrupted by reset SHALL NOT complete or pulse done.

Configuration
REQ-025 SHALL provide macro MULT_ACC_SUB_SAT_EN: when defined, an overflowing result SHALL saturate to 2^(N-1)-1 (positive) or -2^(N-1) (negative). overflow SHALL still assert.
REQ-026 SHALL, without MULT_ACC_SUB_SAT_EN, use wrap behaviour per REQ-019. Latency and handshake SHALL be identical in both builds.

Verification
REQ-027 N=32, mode=0: inA=13, inB=12, inC=100, start pulse -> after 33 edges, ready=1, done pulse, result=56, overflow=0.
REQ-028 N=32: (4,8,59,mode0) -> -27; (10,-2,38,mode1) -> 18; (-10,-2,38,mode0) -> -18; (-1,-2,38,mode0) -> -36; all overflow=0.
REQ-029 N=8, mode=0: inA=127, inB=127, inC=0 -> overflow=1. Result is 1 without the macro. Result is 127 with MULT_ACC_SUB_SAT_EN.
REQ-030 N=8, mode=0: inA=-128, inB=-128, inC=0 -> overflow=1, exact 16384. Result is 0 without the macro. Result is 127 with the macro.
REQ-031 N=32: launch (13,12,100). Assert start with new operands at cycle 5 -> ignored; result=56. Then assert rst at cycle 5 of a second operation -> next edge shows ready=1, result=0, no done pulse.
REQ-032 N=32: start held high for 3 operation periods -> three done pulses, each N+1 edges apart plus one relaunch cycle; ready=1 for one cycle between them.
